// File: rtl/ram_hs_pkg.sv
// Shared types and constants for the handshaked byte RAM.
// Fallback widths apply only when the top macro header has not defined them.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package ram_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Counter only has to hold RD_LAT-1, i.e. at most RD_LAT_MAX-1.
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_bytes.sv
// Byte-wide storage with per-lane synchronous writes and a combinational
// word read; lane addresses wrap modulo the array size.
module ram_bytes #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 16
) (
  input  logic                clk_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [WORD_W/8-1:0] we_i,
  input  logic [WORD_W-1:0]   wdata_i,
  output logic [WORD_W-1:0]   rdata_o
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0]        mem_q    [DEPTH];
  logic [ADDR_W-1:0] lane_addr[BYTES];

  // Truncation to ADDR_W bits gives the wrap from the top byte back to 0.
  always_comb begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_addr[i] = addr_i + ADDR_W'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (we_i[i]) begin
        mem_q[lane_addr[i]] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      rdata_o[8*i +: 8] = mem_q[lane_addr[i]];
    end
  end

endmodule

// File: rtl/ram_hs.sv
// Handshaked single-port byte RAM: one request outstanding, fixed response
// latency, per-lane write strobes and optional alignment checking.
module ram_hs
  import ram_hs_pkg::*;
#(
  parameter int unsigned ADDR_W    = `ADDR_SIZE,
  parameter int unsigned WORD_W    = `WORD_SIZE,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ALIGN_CHK = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  input  logic [WORD_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned BYTES = WORD_W / 8;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              req_ready_q;
  logic              rsp_valid_q;

  logic [ADDR_W-1:0] lane_off;
  logic              misalign;
  logic              accept;
  logic [BYTES-1:0]  wr_en;
  logic [WORD_W-1:0] mem_rdata;

  // Writes commit at the accept edge; reset wins over a simultaneous accept.
  always_comb begin
    lane_off = req_addr % ADDR_W'(BYTES);
    misalign = (ALIGN_CHK != 0) && (lane_off != '0);
    accept   = req_valid && req_ready_q;
    wr_en    = (accept && req_we && !misalign && !rst) ? req_be : '0;
  end

  ram_bytes #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_bytes (
    .clk_i   (clk),
    .addr_i  (req_addr),
    .we_i    (wr_en),
    .wdata_i (req_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            err_q       <= misalign;
            rdata_q     <= (req_we || misalign) ? '0 : mem_rdata;
            if (RD_LAT > 1) begin
              state_q <= ST_WAIT;
              cnt_q   <= lat_load(RD_LAT);
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            err_q       <= 1'b0;
            rdata_q     <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // err_q is captured at accept; masking keeps it invisible until RESP.
  always_comb begin
    req_ready = req_ready_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
    rsp_err   = rsp_valid_q & err_q;
  end

endmodule
